branch_compare_unit: RTL and testbench

Multi-cycle, parametrised branch resolution unit for the RISC-V core. It compares two XLEN-bit register operands in CHUNK-bit slices, scanning from the most significant slice down, and evaluates the full B-type condition set (BEQ/BNE/BLT/BGE/BLTU/BGEU) from funct3. It replaces the single-cycle combinational equal/less-than comparator where area matters more than branch latency. It sits between the register-file read stage and the PC-select logic, and hands off results with a start/done handshake.

---
 rtl/branch_compare_unit_if.sv | 26 ++
 rtl/branch_compare_unit.sv | 156 +++++++++++++++
 tb/tb_branch_compare_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_compare_unit_if.sv
// Start/done handshake bundle between the operand read stage
// and the sliced branch comparator.
interface branch_compare_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            busy;
   logic            done;
   logic            taken;
   logic            br_eq;
   logic            br_lt;
   logic            illegal;

   modport master (
      output start, funct3, rs1, rs2,
      input  busy, done, taken, br_eq, br_lt, illegal
   );

   modport slave (
      input  start, funct3, rs1, rs2,
      output busy, done, taken, br_eq, br_lt, illegal
   );
endinterface

// File: rtl/branch_compare_unit.sv
// Multi-cycle sliced branch comparator, MSB slice first.
// Define BRCMP_EARLY_EXIT_EN to finish at the first differing slice.
module branch_compare_unit #(
   parameter int XLEN  = 32,
   parameter int CHUNK = 8
) (
   input logic                  clk,
   input logic                  rst,
   branch_compare_unit_if.slave bus
);
   localparam int NCHUNK = XLEN / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] TOPIDX = IDXW'(NCHUNK - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, stateNxt;
   logic [XLEN-1:0] opA, opANxt;
   logic [XLEN-1:0] opB, opBNxt;
   logic [2:0]      fn, fnNxt;
   logic [IDXW-1:0] idx, idxNxt;
   logic            diffFound, diffFoundNxt;
   logic            ltFound, ltFoundNxt;
   logic            done, doneNxt;
   logic            taken, takenNxt;
   logic            brEq, brEqNxt;
   logic            brLt, brLtNxt;
   logic            ill, illNxt;

   logic [CHUNK-1:0] sliceA [NCHUNK];
   logic [CHUNK-1:0] sliceB [NCHUNK];
   logic [CHUNK-1:0] curA, curB;
   logic             signedOp, sliceDiff, sliceLt;
   logic             diffAny, ltAny, lastSlice, startIll;

   for (genvar g = 0; g < NCHUNK; g++) begin : gSlice
      assign sliceA[g] = opA[g*CHUNK +: CHUNK];
      assign sliceB[g] = opB[g*CHUNK +: CHUNK];
   end

   assign curA      = sliceA[idx];
   assign curB      = sliceB[idx];
   assign signedOp  = (fn == 3'b100) || (fn == 3'b101);
   assign sliceDiff = curA != curB;
   // Only the top slice carries the sign bit.
   assign sliceLt   = (signedOp && idx == TOPIDX)
                    ? ($signed(curA) < $signed(curB))
                    : (curA < curB);
   assign diffAny   = diffFound | sliceDiff;
   assign ltAny     = diffFound ? ltFound : (sliceDiff & sliceLt);
   assign startIll  = (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b011);

`ifdef BRCMP_EARLY_EXIT_EN
   assign lastSlice = (idx == '0) || diffAny;
`else
   assign lastSlice = (idx == '0);
`endif

   function automatic logic decodeTaken(
      input logic [2:0] f,
      input logic       eq,
      input logic       lt
   );
      logic cond;
      cond = f[2] ? lt : eq;
      return f[0] ? !cond : cond;
   endfunction

   always_comb begin
      stateNxt     = state;
      opANxt       = opA;
      opBNxt       = opB;
      fnNxt        = fn;
      idxNxt       = idx;
      diffFoundNxt = diffFound;
      ltFoundNxt   = ltFound;
      doneNxt      = 1'b0;
      takenNxt     = taken;
      brEqNxt      = brEq;
      brLtNxt      = brLt;
      illNxt       = ill;
      unique case (state)
         IDLE: begin
            if (bus.start && startIll) begin
               doneNxt  = 1'b1;
               illNxt   = 1'b1;
               takenNxt = 1'b0;
               brEqNxt  = 1'b0;
               brLtNxt  = 1'b0;
            end else if (bus.start) begin
               opANxt       = bus.rs1;
               opBNxt       = bus.rs2;
               fnNxt        = bus.funct3;
               idxNxt       = TOPIDX;
               diffFoundNxt = 1'b0;
               ltFoundNxt   = 1'b0;
               stateNxt     = RUN;
            end
         end
         RUN: begin
            if (!diffFound && sliceDiff) begin
               diffFoundNxt = 1'b1;
               ltFoundNxt   = sliceLt;
            end
            if (lastSlice) begin
               brEqNxt  = !diffAny;
               brLtNxt  = ltAny;
               takenNxt = decodeTaken(fn, !diffAny, ltAny);
               illNxt   = 1'b0;
               doneNxt  = 1'b1;
               stateNxt = IDLE;
            end else begin
               idxNxt = idx - IDXW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         opA       <= '0;
         opB       <= '0;
         fn        <= '0;
         idx       <= '0;
         diffFound <= 1'b0;
         ltFound   <= 1'b0;
         done      <= 1'b0;
         taken     <= 1'b0;
         brEq      <= 1'b0;
         brLt      <= 1'b0;
         ill       <= 1'b0;
      end else begin
         state     <= stateNxt;
         opA       <= opANxt;
         opB       <= opBNxt;
         fn        <= fnNxt;
         idx       <= idxNxt;
         diffFound <= diffFoundNxt;
         ltFound   <= ltFoundNxt;
         done      <= doneNxt;
         taken     <= takenNxt;
         brEq      <= brEqNxt;
         brLt      <= brLtNxt;
         ill       <= illNxt;
      end
   end

   assign bus.busy    = (state == RUN);
   assign bus.done    = done;
   assign bus.taken   = taken;
   assign bus.br_eq   = brEq;
   assign bus.br_lt   = brLt;
   assign bus.illegal = ill;
endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench for branch_compare_unit (XLEN=32, CHUNK=8):
// directed table, random ops against a reference model, corner sequences.
module tb_branch_compare_unit;
   localparam int XLEN   = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = XLEN / CHUNK;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nVec = 0;
   int   nMis = 0;

   branch_compare_unit_if #(.XLEN(XLEN)) bus ();

   branch_compare_unit #(
      .XLEN (XLEN),
      .CHUNK(CHUNK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic        tk;
      logic        eq;
      logic        lt;
      logic        ill;
      int          latFull;
      int          latEarly;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer comparisons on whole operands.
   function automatic void model(
      input  logic [2:0]  f,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic tk, output logic eq, output logic lt,
      output logic ill, output int lat
   );
      int first;
      ill = (f == 3'b010) || (f == 3'b011);
      eq  = (a == b);
      if (f == 3'b100 || f == 3'b101) lt = $signed(a) < $signed(b);
      else                            lt = a < b;
      case (f)
         3'b000:         tk = eq;
         3'b001:         tk = !eq;
         3'b100, 3'b110: tk = lt;
         3'b101, 3'b111: tk = !lt;
         default:        tk = 1'b0;
      endcase
      first = -1;
      for (int k = NCHUNK - 1; k >= 0; k--)
         if (first < 0 && ((a >> (k * CHUNK)) & 32'hFF) !=
                          ((b >> (k * CHUNK)) & 32'hFF))
            first = k;
`ifdef BRCMP_EARLY_EXIT_EN
      lat = (first < 0) ? NCHUNK + 1 : NCHUNK - first + 1;
`else
      lat = NCHUNK + 1;
`endif
      if (ill) begin
         eq = 1'b0; lt = 1'b0; tk = 1'b0; lat = 1;
      end
   endfunction

   // Issues one op, scrambles inputs after acceptance, waits for done.
   task automatic runOp(input string nm, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic tk, input logic eq,
                        input logic lt, input logic ill,
                        input int lat);
      int cyc;
      bit busyBad;
      busyBad = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.rs1    = a;
      bus.rs2    = b;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.rs1    = $urandom;
      bus.rs2    = $urandom;
      bus.funct3 = 3'($urandom);
      cyc = 1;
      while (!bus.done && cyc < 20) begin
         if (!bus.busy) busyBad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      check({nm, " latency"}, cyc, lat);
      check({nm, " busy run"}, {31'd0, busyBad}, 0);
      check({nm, " busy@done"}, {31'd0, bus.busy}, 0);
      check({nm, " taken"}, {31'd0, bus.taken}, {31'd0, tk});
      check({nm, " br_eq"}, {31'd0, bus.br_eq}, {31'd0, eq});
      check({nm, " br_lt"}, {31'd0, bus.br_lt}, {31'd0, lt});
      check({nm, " illegal"}, {31'd0, bus.illegal}, {31'd0, ill});
   endtask

   task automatic waitDone(input string nm, input int startCyc,
                           input int lat);
      int cyc;
      cyc = startCyc;
      while (!bus.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, " latency"}, cyc, lat);
   endtask

   initial begin
      logic tk, eq, lt, ill;
      int   lat, doneSeen;
      logic [31:0] a, b;
      logic [2:0]  f;

      bus.start  = 1'b0;
      bus.funct3 = 3'b000;
      bus.rs1    = '0;
      bus.rs2    = '0;

      tbl.push_back('{"beq", 3'b000, 32'h12345678, 32'h12345678,
                      1, 1, 0, 0, 5, 5});
      tbl.push_back('{"blt", 3'b100, 32'hFFFFFFFF, 32'h00000001,
                      1, 0, 1, 0, 5, 2});
      tbl.push_back('{"bltu", 3'b110, 32'hFFFFFFFF, 32'h00000001,
                      0, 0, 0, 0, 5, 2});
      tbl.push_back('{"bgeu", 3'b111, 32'h00000100, 32'h000000FF,
                      1, 0, 0, 0, 5, 4});
      tbl.push_back('{"bge", 3'b101, 32'h80000000, 32'h7FFFFFFF,
                      0, 0, 1, 0, 5, 2});
      tbl.push_back('{"ill010", 3'b010, 32'h1, 32'h2,
                      0, 0, 0, 1, 1, 1});
      tbl.push_back('{"bne_eq", 3'b001, 32'h5, 32'h5,
                      0, 1, 0, 0, 5, 5});
      tbl.push_back('{"bge_eq", 3'b101, 32'hA5A5A5A5, 32'hA5A5A5A5,
                      1, 1, 0, 0, 5, 5});
      tbl.push_back('{"bne_lo", 3'b001, 32'h0000_0010, 32'h0000_0011,
                      1, 0, 1, 0, 5, 5});
      tbl.push_back('{"ill011", 3'b011, 32'h7, 32'h7,
                      0, 0, 0, 1, 1, 1});

      #2;
      check("rst busy", {31'd0, bus.busy}, 0);
      check("rst done", {31'd0, bus.done}, 0);
      check("rst outs", {28'd0, bus.taken, bus.br_eq,
                         bus.br_lt, bus.illegal}, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
`ifdef BRCMP_EARLY_EXIT_EN
         lat = tbl[i].latEarly;
`else
         lat = tbl[i].latFull;
`endif
         runOp(tbl[i].nm, tbl[i].f, tbl[i].a, tbl[i].b,
               tbl[i].tk, tbl[i].eq, tbl[i].lt, tbl[i].ill, lat);
      end

      for (int i = 0; i < 150; i++) begin
         f = 3'($urandom);
         a = $urandom;
         case ($urandom_range(0, 2))
            0: b = $urandom;
            1: b = a;
            default: b = a ^ (32'($urandom_range(1, 255)) <<
                              (8 * $urandom_range(0, 3)));
         endcase
         model(f, a, b, tk, eq, lt, ill, lat);
         runOp("rand", f, a, b, tk, eq, lt, ill, lat);
      end

      // Restart attempt mid-run is ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b001;
      bus.rs1 = 32'd5; bus.rs2 = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.rs1 = 32'd6; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone("restart", 3, 5);
      check("restart taken", {31'd0, bus.taken}, 0);
      check("restart br_eq", {31'd0, bus.br_eq}, 1);

      // Start accepted in the done cycle.
      bus.start = 1'b1; bus.funct3 = 3'b110;
      bus.rs1 = 32'd1; bus.rs2 = 32'd2;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b busy", {31'd0, bus.busy}, 1);
      waitDone("b2b", 1, 5);
      check("b2b taken", {31'd0, bus.taken}, 1);
      check("b2b br_lt", {31'd0, bus.br_lt}, 1);
      @(negedge clk);
      check("hold done", {31'd0, bus.done}, 0);
      check("hold taken", {31'd0, bus.taken}, 1);

      // Asynchronous abort in cycle 2 of a BLTU op.
      bus.start = 1'b1; bus.funct3 = 3'b110;
      bus.rs1 = 32'd1; bus.rs2 = 32'd2;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort busy", {31'd0, bus.busy}, 0);
      check("abort done", {31'd0, bus.done}, 0);
      check("abort outs", {28'd0, bus.taken, bus.br_eq,
                           bus.br_lt, bus.illegal}, 0);
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) doneSeen++;
      end
      check("abort no done", doneSeen, 0);
      model(3'b110, 32'hF0, 32'h0F, tk, eq, lt, ill, lat);
      runOp("post rst", 3'b110, 32'hF0, 32'h0F, tk, eq, lt, ill, lat);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end
endmodule
